// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-port register file with zero register, bypass and optional registered read
module regfile_mp #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1,
  parameter int READ_REG = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         RegWrite,
  input  logic [ADDR_W-1:0]            WriteRegister,
  input  logic [WIDTH-1:0]             WriteData,
  input  logic [NREAD-1:0][ADDR_W-1:0] ReadRegister,
  output logic [NREAD-1:0][WIDTH-1:0]  ReadData
);

  // Indices are compared at 32 bits so that ZERO_REG == DEPTH (disabled)
  // never aliases onto a real entry when DEPTH is a power of two.
  localparam logic [31:0] ZERO_IDX = 32'(ZERO_REG);
  localparam logic [31:0] DEPTH_U  = 32'(DEPTH);

  logic [WIDTH-1:0]            r_mem [DEPTH];
  logic [NREAD-1:0][WIDTH-1:0] w_raw;
  logic [31:0]                 w_wr_idx;
  logic                        w_wr_ok;

  assign w_wr_idx = 32'(WriteRegister);
  assign w_wr_ok  = (w_wr_idx != ZERO_IDX) && (w_wr_idx < DEPTH_U);

  // Storage: reset clears every entry and wins over a same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k] <= '0;
      end
    end else if (RegWrite && w_wr_ok) begin
      r_mem[WriteRegister] <= WriteData;
    end
  end

  // Raw read per port: zero register, out-of-range, bypass, then storage.
  // Only the index compare of the bypass touches the write side here.
  always_comb begin
    w_raw = '0;
    for (int i = 0; i < NREAD; i++) begin
      if (32'(ReadRegister[i]) == ZERO_IDX) begin
        w_raw[i] = '0;
      end else if (32'(ReadRegister[i]) >= DEPTH_U) begin
        w_raw[i] = '0;
      end else if ((BYPASS == 1) && RegWrite && !reset &&
                   (WriteRegister == ReadRegister[i])) begin
        w_raw[i] = WriteData;
      end else begin
        w_raw[i] = r_mem[ReadRegister[i]];
      end
    end
  end

  generate
    if (READ_REG == 1) begin : g_reg_read
      logic [NREAD-1:0][WIDTH-1:0] r_rdata;

      // Registered read: one cycle of latency, cleared by reset.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_rdata <= '0;
        end else begin
          r_rdata <= w_raw;
        end
      end

      assign ReadData = r_rdata;
    end else begin : g_comb_read
      assign ReadData = w_raw;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp
module tb_regfile_mp;

  logic             clk;
  logic             reset;
  logic             we;
  logic [4:0]       wa;
  logic [63:0]      wd;
  logic [1:0][4:0]  ra;
  logic [1:0][63:0] rd_c;
  logic [1:0][63:0] rd_nb;
  logic [1:0][63:0] rd_r;

  logic             s_we;
  logic [3:0]       s_wa;
  logic [31:0]      s_wd;
  logic [2:0][3:0]  s_ra;
  logic [2:0][31:0] s_rd;

  int n_checks = 0;
  int n_errors = 0;

  regfile_mp #(.BYPASS(1), .READ_REG(0)) u_comb (
    .clk(clk), .reset(reset), .RegWrite(we), .WriteRegister(wa),
    .WriteData(wd), .ReadRegister(ra), .ReadData(rd_c)
  );

  regfile_mp #(.BYPASS(0), .READ_REG(0)) u_nobyp (
    .clk(clk), .reset(reset), .RegWrite(we), .WriteRegister(wa),
    .WriteData(wd), .ReadRegister(ra), .ReadData(rd_nb)
  );

  regfile_mp #(.BYPASS(1), .READ_REG(1)) u_reg (
    .clk(clk), .reset(reset), .RegWrite(we), .WriteRegister(wa),
    .WriteData(wd), .ReadRegister(ra), .ReadData(rd_r)
  );

  regfile_mp #(.WIDTH(32), .DEPTH(16), .NREAD(3), .ZERO_REG(16)) u_small (
    .clk(clk), .reset(reset), .RegWrite(s_we), .WriteRegister(s_wa),
    .WriteData(s_wd), .ReadRegister(s_ra), .ReadData(s_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pat(input int i);
    return 64'h1111_0000_0000_0000 + 64'(i);
  endfunction

  initial begin
    reset = 1'b1; we = 1'b0; wa = '0; wd = '0; ra = '0;
    s_we = 1'b0; s_wa = '0; s_wd = '0; s_ra = '0;

    // Reset, then sweep all indices
    tick();
    reset = 1'b0;
    check("reg_after_reset_p0", rd_r[0], 64'h0);
    check("reg_after_reset_p1", rd_r[1], 64'h0);
    for (int i = 0; i < 32; i++) begin
      ra[0] = 5'(i);
      #1;
      check($sformatf("reset_sweep_c[%0d]", i), rd_c[0], 64'h0);
      check($sformatf("reset_sweep_nb[%0d]", i), rd_nb[0], 64'h0);
    end

    // Write pattern, then try to write the zero register
    for (int i = 0; i < 31; i++) begin
      we = 1'b1; wa = 5'(i); wd = pat(i);
      tick();
    end
    wa = 5'd31; wd = 64'hDEAD;
    tick();
    we = 1'b0;

    // Sweep both ports, port 1 reversed
    for (int i = 0; i < 32; i++) begin
      ra[0] = 5'(i);
      ra[1] = 5'(31 - i);
      #1;
      check($sformatf("sweep_c0[%0d]", i), rd_c[0], (i == 31) ? 64'h0 : pat(i));
      check($sformatf("sweep_c1[%0d]", 31 - i), rd_c[1], (i == 0) ? 64'h0 : pat(31 - i));
      check($sformatf("sweep_nb0[%0d]", i), rd_nb[0], (i == 31) ? 64'h0 : pat(i));
      tick();
      check($sformatf("sweep_r0[%0d]", i), rd_r[0], (i == 31) ? 64'h0 : pat(i));
      check($sformatf("sweep_r1[%0d]", 31 - i), rd_r[1], (i == 0) ? 64'h0 : pat(31 - i));
    end

    // Bypass vs no bypass, both ports on the written index
    we = 1'b1; wa = 5'd5; wd = 64'hCAFE; ra[0] = 5'd5; ra[1] = 5'd5;
    #1;
    check("bypass_c_p0", rd_c[0], 64'hCAFE);
    check("bypass_c_p1", rd_c[1], 64'hCAFE);
    check("nobypass_old", rd_nb[0], pat(5));
    tick();
    we = 1'b0;
    #1;
    check("nobypass_after_edge", rd_nb[0], 64'hCAFE);
    check("reg_bypass_capture", rd_r[0], 64'hCAFE);
    check("reg_bypass_capture_p1", rd_r[1], 64'hCAFE);

    // Write zero register while reading it
    we = 1'b1; wa = 5'd31; wd = 64'hDEAD; ra[0] = 5'd31;
    #1;
    check("zero_reg_write_read", rd_c[0], 64'h0);
    tick();
    we = 1'b0;
    #1;
    check("zero_reg_after_edge", rd_nb[0], 64'h0);

    // Registered read latency
    we = 1'b1; wa = 5'd7; wd = 64'h77; ra[1] = 5'd0;
    tick();
    we = 1'b0;
    check("reg_prev_p1", rd_r[1], pat(0));
    ra[1] = 5'd7;
    #1;
    check("reg_latency_hold", rd_r[1], pat(0));
    tick();
    check("reg_read_77", rd_r[1], 64'h77);
    we = 1'b1; wa = 5'd7; wd = 64'h88;
    #1;
    check("reg_before_edge_77", rd_r[1], 64'h77);
    tick();
    we = 1'b0;
    check("reg_same_cycle_88", rd_r[1], 64'h88);

    // Reset overrides a same-cycle write; bypass suppressed during reset
    reset = 1'b1; we = 1'b1; wa = 5'd3; wd = 64'hFF; ra[0] = 5'd3; ra[1] = 5'd7;
    #1;
    check("reset_no_bypass", rd_c[0], pat(3));
    tick();
    reset = 1'b0; we = 1'b0;
    #1;
    check("reset_wr_ignored_c", rd_c[0], 64'h0);
    check("reset_wr_ignored_nb", rd_nb[0], 64'h0);
    check("reset_clears_7", rd_c[1], 64'h0);
    check("reg_zero_after_reset", rd_r[0], 64'h0);
    tick();
    check("reg_mem3_zero", rd_r[0], 64'h0);
    check("reg_mem7_zero", rd_r[1], 64'h0);

    // Narrow, 16-deep, 3-port instance with the zero register disabled
    for (int i = 0; i < 16; i++) begin
      s_we = 1'b1; s_wa = 4'(i); s_wd = 32'hA5A5_0000 + 32'(i);
      tick();
    end
    s_we = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s_ra[0] = 4'(i);
      s_ra[1] = 4'(15 - i);
      s_ra[2] = 4'((i + 5) % 16);
      #1;
      check($sformatf("small_p0[%0d]", i), 64'(s_rd[0]), 64'(32'hA5A5_0000 + 32'(i)));
      check($sformatf("small_p1[%0d]", 15 - i), 64'(s_rd[1]), 64'(32'hA5A5_0000 + 32'(15 - i)));
      check($sformatf("small_p2[%0d]", (i + 5) % 16), 64'(s_rd[2]),
            64'(32'hA5A5_0000 + 32'((i + 5) % 16)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
